bcd_serial_adder: RTL



---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd_digit_cell.sv | 19 +
 rtl/bcd_serial_adder.sv | 116 +++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and digit helpers for the digit-serial BCD adder.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_ADJ = 4'd6;

    function automatic logic [3:0] nines(input logic [3:0] d);
        return BCD_MAX - d;
    endfunction

    function automatic logic dig_ok(input logic [3:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One decimal digit add with +6 correction; shared across all digit slots.
module bcd_digit_cell (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] d,
    output logic       co
);
    import bcd_pkg::*;

    logic [4:0] t;

    always_comb begin
        t  = {1'b0, x} + {1'b0, y} + {4'b0, ci};
        co = t > {1'b0, BCD_MAX};
        d  = co ? t[3:0] + BCD_ADJ : t[3:0];
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                sub,
    input  logic                cin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                err
);
    import bcd_pkg::*;

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    state_t        state;
    state_t        nxt;
    logic [W-1:0]  opa;
    logic [W-1:0]  opb;
    logic [W-1:0]  bx;
    logic [W-1:0]  res_nxt;
    logic [CW-1:0] idx;
    logic          c;
    logic          acc;
    logic          fin;
    logic          bad;
    logic [3:0]    dg;
    logic          co;

    always_comb begin
        nxt = state;
        acc = 1'b0;
        fin = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    acc = 1'b1;
                    nxt = RUN;
                end
            end
            RUN: begin
                if (idx == LAST) begin
                    fin = 1'b1;
                    nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Subtraction is a + nines(b) with the borrow-in inverted as carry.
    always_comb begin
        bx  = '0;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            bx[4*i +: 4] = sub ? nines(b[4*i +: 4]) : b[4*i +: 4];
            bad = bad | !dig_ok(a[4*i +: 4]) | !dig_ok(b[4*i +: 4]);
        end
    end

    bcd_digit_cell u_cell (
        .x  (opa[3:0]),
        .y  (opb[3:0]),
        .ci (c),
        .d  (dg),
        .co (co)
    );

    assign res_nxt = (sum >> 4) | (W'(dg) << (W - 4));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            err       <= 1'b0;
            opa       <= '0;
            opb       <= '0;
            idx       <= '0;
            c         <= 1'b0;
        end else begin
            state     <= nxt;
            in_ready  <= nxt == IDLE;
            out_valid <= nxt == DONE;
            if (acc) begin
                opa <= a;
                opb <= bx;
                c   <= sub ? !cin : cin;
                idx <= '0;
                err <= bad;
            end else if (state == RUN) begin
                opa <= opa >> 4;
                opb <= opb >> 4;
                c   <= co;
                idx <= idx + CW'(1);
                sum <= res_nxt;
                if (fin) cout <= co;
            end
        end
    end

endmodule
